// File: rtl/serializer_pkg.sv
// Shared types and length-decoding helpers for the parallel-to-serial stream converter.
package serializer_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  // A length field of zero means a full-width word.
  function automatic int unsigned decode_len(input int unsigned mod, input int unsigned data_w);
    return (mod == 0) ? data_w : mod;
  endfunction

  function automatic logic mod_legal(input int unsigned mod, input int unsigned data_w);
    return (mod <= data_w);
  endfunction

endpackage

// File: rtl/serializer_stream_if.sv
// Word-in / bit-out bus of the serializer: valid/ready word handshake plus serial outputs.
interface serializer_stream_if #(
  parameter int DATA_W = 16
);
  localparam int MOD_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              msb_first_i;
  logic              data_val_i;
  logic              data_rdy_o;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              ser_last_o;
  logic              busy_o;
  logic              mod_err_o;

  modport master (
    output data_i, data_mod_i, msb_first_i, data_val_i,
    input  data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, busy_o, mod_err_o
  );

  modport slave (
    input  data_i, data_mod_i, msb_first_i, data_val_i,
    output data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, busy_o, mod_err_o
  );

endinterface

// File: rtl/serializer_hold_buf.sv
// One-entry holding register for a decoded word; when empty the input passes straight through.
module serializer_hold_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         full_next
);

  logic [W-1:0] word_q;

  always_comb begin
    full_next = full;
    if (push) begin
      full_next = 1'b1;
    end else if (pop) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      word_q <= '0;
      full   <= 1'b0;
    end else begin
      full <= full_next;
      if (push) begin
        word_q <= din;
      end
    end
  end

  // Bypass: an empty buffer presents the incoming word so the shifter can load it directly.
  assign dout = full ? word_q : din;

endmodule

// File: rtl/serializer_stream.sv
// Parallel-to-serial converter with per-word length and bit order, gapless via a one-word buffer.
module serializer_stream
  import serializer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input logic              clk_i,
  input logic              arst_ni,
  serializer_stream_if.slave bus
);

  localparam int MOD_W = $clog2(DATA_W) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  len;
    logic              msb_first;
  } ser_word_t;

  localparam int WORD_W = $bits(ser_word_t);

  ser_word_t         in_word;
  ser_word_t         load_word;
  logic [WORD_W-1:0] hold_dout;
  ser_state_t        state;
  ser_state_t        state_next;
  logic [DATA_W-1:0] shreg;
  logic [MOD_W-1:0]  cnt;
  logic              msb_q;
  logic              ser_data;
  logic              ser_val;
  logic              ser_last;
  logic              rdy;
  logic              busy;
  logic              mod_err;
  logic              legal;
  logic              accept;
  logic              acc_legal;
  logic              last;
  logic              load;
  logic              push;
  logic              pop;
  logic              full;
  logic              full_next;

  always_comb begin
    in_word.data      = bus.data_i;
    in_word.len       = MOD_W'(decode_len(32'(bus.data_mod_i), 32'(DATA_W)));
    in_word.msb_first = bus.msb_first_i;
    legal             = mod_legal(32'(bus.data_mod_i), 32'(DATA_W));
  end

  assign accept    = bus.data_val_i & rdy;
  assign acc_legal = accept & legal;
  assign last      = (state == S_SHIFT) && (cnt == '0);
  assign pop       = load & full;
  assign load_word = hold_dout;

  serializer_hold_buf #(
    .W (WORD_W)
  ) u_hold (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .push      (push),
    .pop       (pop),
    .din       (in_word),
    .dout      (hold_dout),
    .full      (full),
    .full_next (full_next)
  );

  // On the last bit a held word wins; with no held word, a word accepted on that edge bypasses.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    push       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc_legal) begin
          load       = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last) begin
          if (full || acc_legal) begin
            load = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else if (acc_legal) begin
          push = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state    <= S_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      msb_q    <= 1'b0;
      ser_data <= 1'b0;
      ser_val  <= 1'b0;
      ser_last <= 1'b0;
      rdy      <= 1'b0;
      busy     <= 1'b0;
      mod_err  <= 1'b0;
    end else begin
      state   <= state_next;
      rdy     <= !full_next;
      busy    <= (state_next == S_SHIFT) || full_next;
      mod_err <= accept & !legal;
      if (load) begin
        ser_val  <= 1'b1;
        msb_q    <= load_word.msb_first;
        cnt      <= load_word.len - MOD_W'(1);
        ser_last <= (load_word.len == MOD_W'(1));
        if (load_word.msb_first) begin
          ser_data <= load_word.data[DATA_W-1];
          shreg    <= load_word.data << 1;
        end else begin
          ser_data <= load_word.data[0];
          shreg    <= load_word.data >> 1;
        end
      end else if ((state == S_SHIFT) && !last) begin
        cnt      <= cnt - MOD_W'(1);
        ser_last <= (cnt == MOD_W'(1));
        if (msb_q) begin
          ser_data <= shreg[DATA_W-1];
          shreg    <= shreg << 1;
        end else begin
          ser_data <= shreg[0];
          shreg    <= shreg >> 1;
        end
      end else begin
        ser_data <= 1'b0;
        ser_val  <= 1'b0;
        ser_last <= 1'b0;
      end
    end
  end

  assign bus.data_rdy_o     = rdy;
  assign bus.ser_data_o     = ser_data;
  assign bus.ser_data_val_o = ser_val;
  assign bus.ser_last_o     = ser_last;
  assign bus.busy_o         = busy;
  assign bus.mod_err_o      = mod_err;

endmodule

// File: tb/tb_serializer_stream.sv
// Directed and random checks of serializer_stream (DATA_W=16) against a bit-queue reference model.
module tb_serializer_stream;

  localparam int DW = 16;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic arst_ni;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   err_due = 1'b0;
  exp_t exp_q[$];

  serializer_stream_if #(.DATA_W(DW)) bus();

  serializer_stream #(.DATA_W(DW)) dut (
    .clk_i   (clk),
    .arst_ni (arst_ni),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every accepted legal word becomes its list of bits in send order.
  task automatic model_push(input logic [DW-1:0] d, input logic [4:0] mod, input bit msb);
    int len;
    if (int'(mod) > DW) begin
      err_due = 1'b1;
      return;
    end
    len = (mod == 0) ? DW : int'(mod);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.b    = msb ? d[DW-1-i] : d[i];
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] d, input logic [4:0] mod, input bit msb,
                                input bit hold);
    bit accepted;
    accepted        = 1'b0;
    bus.data_i      = d;
    bus.data_mod_i  = mod;
    bus.msb_first_i = msb;
    bus.data_val_i  = 1'b1;
    for (int t = 0; t < 100 && !accepted; t++) begin
      @(negedge clk);
      if (bus.data_rdy_o === 1'b1) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    check_output("accept", accepted, 1);
    if (accepted) model_push(d, mod, msb);
    if (!hold) bus.data_val_i = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && bus.ser_data_val_o === 1'b0 && bus.busy_o === 1'b0) done = 1'b1;
    end
    check_output("drain", done, 1);
    @(posedge clk);
    #1;
  endtask

  // Pending bits imply a continuous stream; two or more pending words imply a full buffer.
  always @(negedge clk) begin : monitor
    int   words;
    exp_t e;
    if (mon_en) begin
      words = 0;
      foreach (exp_q[i]) if (exp_q[i].last) words++;
      check_output("ser_val", bus.ser_data_val_o, exp_q.size() != 0);
      check_output("busy", bus.busy_o, exp_q.size() != 0);
      check_output("rdy", bus.data_rdy_o, words < 2);
      if (exp_q.size() != 0 && bus.ser_data_val_o === 1'b1) begin
        e = exp_q.pop_front();
        check_output("ser_bit", bus.ser_data_o, e.b);
        check_output("ser_last", bus.ser_last_o, e.last);
      end else begin
        check_output("idle_last", bus.ser_last_o, 0);
      end
      check_output("mod_err", bus.mod_err_o, err_due);
      err_due = 1'b0;
    end
  end

  initial begin
    bus.data_i      = '0;
    bus.data_mod_i  = '0;
    bus.msb_first_i = 1'b0;
    bus.data_val_i  = 1'b0;
    arst_ni         = 1'b1;
    #1 arst_ni = 1'b0;
    #1;
    check_output("rst_rdy", bus.data_rdy_o, 0);
    check_output("rst_val", bus.ser_data_val_o, 0);
    check_output("rst_data", bus.ser_data_o, 0);
    check_output("rst_last", bus.ser_last_o, 0);
    check_output("rst_busy", bus.busy_o, 0);
    check_output("rst_err", bus.mod_err_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) arst_ni = 1'b1;
    @(posedge clk);
    #1;
    check_output("rdy_after_rst", bus.data_rdy_o, 1);
    mon_en = 1'b1;

    $display("[TB] full-width MSB-first word");
    apply_stimulus(16'hA5C3, 5'd0, 1'b1, 1'b0);
    check_output("t1_first_val", bus.ser_data_val_o, 1);
    check_output("t1_first_bit", bus.ser_data_o, 1);
    check_output("t1_busy", bus.busy_o, 1);
    repeat (15) begin @(posedge clk); #1; end
    check_output("t1_last16", bus.ser_last_o, 1);
    check_output("t1_bit16", bus.ser_data_o, 1);
    @(posedge clk);
    #1;
    check_output("t1_val_end", bus.ser_data_val_o, 0);
    check_output("t1_busy_end", bus.busy_o, 0);
    wait_drain();

    $display("[TB] short words, both orders");
    apply_stimulus(16'hA5C3, 5'd4, 1'b0, 1'b0);
    wait_drain();
    apply_stimulus(16'hA5C3, 5'd4, 1'b1, 1'b0);
    wait_drain();

    $display("[TB] back-to-back words with valid held");
    apply_stimulus(16'hFFFF, 5'd3, 1'b1, 1'b1);
    apply_stimulus(16'h0000, 5'd2, 1'b1, 1'b1);
    apply_stimulus(16'hFFFF, 5'd1, 1'b1, 1'b0);
    wait_drain();

    $display("[TB] illegal lengths");
    apply_stimulus(16'h1234, 5'd17, 1'b1, 1'b0);
    check_output("t4_err_idle", bus.mod_err_o, 1);
    check_output("t4_no_val", bus.ser_data_val_o, 0);
    @(posedge clk);
    #1;
    check_output("t4_err_pulse", bus.mod_err_o, 0);
    apply_stimulus(16'hA5C3, 5'd0, 1'b1, 1'b0);
    apply_stimulus(16'hFFFF, 5'd17, 1'b0, 1'b0);
    check_output("t4_err_shift", bus.mod_err_o, 1);
    apply_stimulus(16'h00F0, 5'd8, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] reset mid-word with a held word");
    apply_stimulus(16'hA5C3, 5'd0, 1'b1, 1'b0);
    apply_stimulus(16'h0F0F, 5'd5, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    mon_en  = 1'b0;
    arst_ni = 1'b0;
    #1;
    check_output("t5_val", bus.ser_data_val_o, 0);
    check_output("t5_last", bus.ser_last_o, 0);
    check_output("t5_data", bus.ser_data_o, 0);
    check_output("t5_busy", bus.busy_o, 0);
    check_output("t5_rdy", bus.data_rdy_o, 0);
    exp_q.delete();
    err_due = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) arst_ni = 1'b1;
    @(posedge clk);
    #1;
    check_output("t5_rdy_rise", bus.data_rdy_o, 1);
    check_output("t5_no_resume", bus.ser_data_val_o, 0);
    mon_en = 1'b1;
    apply_stimulus(16'h1234, 5'd0, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] random words");
    for (int n = 0; n < 60; n++) begin
      logic [DW-1:0] d;
      logic [4:0]    mod;
      bit            msb;
      bit            hold;
      d    = DW'($urandom);
      mod  = 5'($urandom_range(0, 17));
      msb  = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 2) != 0) && (n != 59);
      apply_stimulus(d, mod, msb, hold);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
